wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//  Write-back sequencer: the writing end of the register-file write port (rd/we/data_in).
//  Merges single-cycle ALU results with in-order, variable-latency load returns.
//  Tracks pending load destinations in a queue plus busy scoreboard; raises stall for RAW hazards.
//  Sits between execute/data-memory and the register file; decode uses stall.
// PARAMETERS
//  W      32  data width
//  N      5   register address width (2**N registers; x0 hard-wired zero)
//  DEPTH  2   max outstanding loads (queue entries), >=1
// PORTS
//  clk            in   1              clock, all state on posedge
//  rst            in   1              asynchronous, active-high reset
//  alu_valid      in   1              ALU result offered this cycle
//  alu_rd         in   N              ALU destination register
//  alu_data       in   W              ALU result
//  alu_ready      out  1              ALU result accepted this cycle (comb)
//  ld_issue_valid in   1              load issued to memory this cycle
//  ld_issue_rd    in   N              load destination register
//  ld_issue_ready out  1              load issue accepted this cycle (comb)
//  mem_rvalid     in   1              load data returning (in issue order)
//  mem_rdata      in   W              returned load data
//  rs1, rs2       in   N              decode-stage source registers
//  stall          out  1              RAW hazard on rs1/rs2 (comb)
//  rd             out  N              register-file write address (registered)
//  we             out  1              register-file write enable (registered)
//  data_in        out  W              register-file write data (registered)
//  pending_cnt    out  $clog2(DEPTH+1) loads outstanding (registered)
//  err_spurious   out  1              sticky: mem_rvalid seen with empty queue
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): queue emptied, busy[] all 0, rd=0, we=0,
//   data_in=0, pending_cnt=0, err_spurious=0. In-flight loads are forgotten; later returns are spurious.
//  One regfile write per cycle. Output regs load at posedge; regfile commits at the next posedge
//   (accept -> regfile updated = 2 edges).
//  Arbitration, per cycle:
//   - load_ret = mem_rvalid && pending_cnt!=0 -> pop queue head, output {head_rd, mem_rdata},
//     we=(head_rd!=0), clear busy[head_rd].
//   - alu_ready = !load_ret && !(alu_rd!=0 && busy[alu_rd]). alu_ready does not depend on alu_valid.
//     Accept when alu_valid&&alu_ready -> output {alu_rd, alu_data}, we=(alu_rd!=0).
//   - If neither: we<=0; rd/data_in hold.
//  Load issue: ld_issue_ready = pending_cnt<DEPTH && !(ld_issue_rd!=0 && busy[ld_issue_rd]).
//   Accept -> push ld_issue_rd; set busy[ld_issue_rd] if nonzero. x0 loads queued, data discarded.
//   Evaluated on pre-edge state: a same-cycle pop does not free a slot or bit for the issue.
//  Same cycle, ALU accept to X and load issue to X: both allowed; ALU write precedes load write.
//  Loads return strictly in issue order; queue is a circular buffer with wrapping pointers.
//   pending_cnt +1 on issue, -1 on return, unchanged when both occur.
//  mem_rvalid with pending_cnt==0: ignored, no write, err_spurious<=1 until reset.
//  stall = for s in {rs1,rs2}: s!=0 && (busy[s] || (we && rd==s)). rs==0 never stalls.
// TESTING
//  1 ALU x5=0xDEADBEEF -> next edge rd=5,we=1,data_in=0xDEADBEEF; x0 write -> we=0.
//  2 Issue load x7, rs1=7 -> stall=1; rvalid data 0x1234 -> we=1,rd=7; stall holds that cycle, drops after.
//  3 Issue x3,x4 (DEPTH=2) -> ld_issue_ready=0, pending_cnt=2; returns 0xA,0xB -> x3=0xA then x4=0xB in order.
//  4 rvalid with ALU valid to x9 -> alu_ready=0, load written; ALU x9 accepted next cycle.
//  5 Issue load x8, then ALU to x8 -> alu_ready=0 until load returns; issue x8 again -> ready=0.
//  6 rst mid-flight with 2 pending -> all outputs 0; later rvalid -> err_spurious=1, no write.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer: writing end of the register-file write port.
//   Merges single-cycle ALU results with in-order, variable-latency load
//   returns. It tracks pending load destinations in a circular queue and in a
//   busy scoreboard, and it raises stall on read-after-write hazards.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data        ALU result offer; alu_ready accepts (comb)
//   ld_issue_valid/ld_issue_rd       load issue; ld_issue_ready accepts (comb)
//   mem_rvalid/mem_rdata             in-order load data return
//   rs1, rs2 -> stall                decode hazard check (comb)
//   rd, we, data_in                  registered register-file write port
//   pending_cnt                      loads outstanding (registered)
//   err_spurious                     sticky: return seen with empty queue
module wb_sequencer #(
  parameter int W     = 32,
  parameter int N     = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [N-1:0]               alu_rd,
  input  logic [W-1:0]               alu_data,
  output logic                       alu_ready,
  input  logic                       ld_issue_valid,
  input  logic [N-1:0]               ld_issue_rd,
  output logic                       ld_issue_ready,
  input  logic                       mem_rvalid,
  input  logic [W-1:0]               mem_rdata,
  input  logic [N-1:0]               rs1,
  input  logic [N-1:0]               rs2,
  output logic                       stall,
  output logic [N-1:0]               rd,
  output logic                       we,
  output logic [W-1:0]               data_in,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
  output logic                       err_spurious
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NREG = 2 ** N;

  logic [N-1:0]    queue_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [N-1:0]    rd_q, rd_d;
  logic            we_q, we_d;
  logic [W-1:0]    data_q, data_d;
  logic            err_q, err_d;

  logic [N-1:0]    head_rd;
  logic            load_ret;
  logic            alu_acc;
  logic            ld_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_rd  = queue_q[head_q];
  assign load_ret = mem_rvalid && (cnt_q != '0);

  // Load returns always win the write port; a busy ALU destination must wait
  // so that a younger ALU write cannot be overwritten by an older load.
  assign alu_ready = !load_ret && !((alu_rd != '0) && busy_q[alu_rd]);
  assign alu_acc   = alu_valid && alu_ready;

  // Uses pre-edge state only: a same-cycle pop does not free a slot or bit.
  assign ld_issue_ready = (cnt_q < CW'(DEPTH)) &&
                          !((ld_issue_rd != '0) && busy_q[ld_issue_rd]);
  assign ld_acc         = ld_issue_valid && ld_issue_ready;

  // Hazard per source: pending load, or write sitting in the output register
  // that the register file has not yet committed.
  logic [N-1:0] src [2];
  logic [1:0]   src_stall;
  assign src[0] = rs1;
  assign src[1] = rs2;
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_stall[gi] = (src[gi] != '0) &&
                           (busy_q[src[gi]] || (we_q && (rd_q == src[gi])));
  end
  assign stall = |src_stall;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + CW'(ld_acc) - CW'(load_ret);
    busy_d = busy_q;
    rd_d   = rd_q;
    we_d   = 1'b0;
    data_d = data_q;
    err_d  = err_q;

    if (load_ret) begin
      head_d          = ptr_inc(head_q);
      busy_d[head_rd] = 1'b0;
      rd_d            = head_rd;
      data_d          = mem_rdata;
      we_d            = (head_rd != '0);
    end else if (alu_acc) begin
      rd_d   = alu_rd;
      data_d = alu_data;
      we_d   = (alu_rd != '0);
    end

    if (ld_acc) begin
      tail_d = ptr_inc(tail_q);
      if (ld_issue_rd != '0) begin
        busy_d[ld_issue_rd] = 1'b1;
      end
    end

    if (mem_rvalid && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // Queue storage needs no reset: entries are only read while cnt_q != 0.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      queue_q[tail_q] <= ld_issue_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign rd           = rd_q;
  assign we           = we_q;
  assign data_in      = data_q;
  assign pending_cnt  = cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_issue_ready;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        stall;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] data_in;
  logic [1:0]  pending_cnt;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  wb_sequencer #(.W(32), .N(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .rd(rd), .we(we), .data_in(data_in),
    .pending_cnt(pending_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outstanding loads are a plain queue of destinations; "busy" is simply
  // membership of a nonzero register in that queue.
  logic [4:0]  mq[$];
  logic [4:0]  m_rd   = '0;
  logic        m_we   = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_err  = 1'b0;

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall1(input logic [4:0] s);
    return (s != 5'd0) && (m_busy(s) || (m_we && m_rd == s));
  endfunction

  // Inputs change just after posedge, so at negedge they are exactly what the
  // next posedge will sample.
  always @(negedge clk) begin
    if (started) begin
      bit          e_ret, e_alu_rdy, e_ld_rdy, e_stall;
      int          pre_size;
      logic [4:0]  h;
      if (rst) begin
        mq.delete();
        m_rd = '0; m_we = 1'b0; m_data = '0; m_err = 1'b0;
      end
      pre_size  = mq.size();
      e_ret     = mem_rvalid && (pre_size != 0);
      e_alu_rdy = !e_ret && !m_busy(alu_rd);
      e_ld_rdy  = (pre_size < DEPTH) && !m_busy(ld_issue_rd);
      e_stall   = m_stall1(rs1) || m_stall1(rs2);

      chk("rd", 32'(rd), 32'(m_rd));
      chk("we", 32'(we), 32'(m_we));
      chk("data_in", data_in, m_data);
      chk("pending_cnt", 32'(pending_cnt), 32'(pre_size));
      chk("err_spurious", 32'(err_spurious), 32'(m_err));
      chk("alu_ready", 32'(alu_ready), 32'(e_alu_rdy));
      chk("ld_issue_ready", 32'(ld_issue_ready), 32'(e_ld_rdy));
      chk("stall", 32'(stall), 32'(e_stall));

      if (!rst) begin
        if (e_ret) begin
          h = mq.pop_front();
          m_rd = h; m_data = mem_rdata; m_we = (h != 5'd0);
          $display("load return rd=%0d data=%h we=%0d", h, mem_rdata, m_we);
        end else if (alu_valid && e_alu_rdy) begin
          m_rd = alu_rd; m_data = alu_data; m_we = (alu_rd != 5'd0);
          $display("alu write rd=%0d data=%h we=%0d", alu_rd, alu_data, m_we);
        end else begin
          m_we = 1'b0;
        end
        if (ld_issue_valid && e_ld_rdy) begin
          mq.push_back(ld_issue_rd);
          $display("load issue rd=%0d", ld_issue_rd);
        end
        if (mem_rvalid && pre_size == 0) begin
          m_err = 1'b1;
          $display("spurious return data=%h", mem_rdata);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_issue_valid = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2 rst = 1'b1;
    started = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_data", data_in, 32'd0);
    chk("reset_pending", 32'(pending_cnt), 32'd0);

    // 1: ALU write, then x0 write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    cyc();
    chk("t1_rd", 32'(rd), 32'd5);
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_data", data_in, 32'hDEADBEEF);
    alu_rd = 5'd0; alu_data = 32'h55;
    cyc();
    chk("t1_x0_we", 32'(we), 32'd0);
    idle(); cyc();

    // 2: load x7 stalls rs1=7 until the write is committed
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
    cyc();
    ld_issue_valid = 1'b0; rs1 = 5'd7;
    #1 chk("t2_stall_pending", 32'(stall), 32'd1);
    chk("t2_pending", 32'(pending_cnt), 32'd1);
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1 chk("t2_stall_ret", 32'(stall), 32'd1);
    cyc();
    mem_rvalid = 1'b0;
    chk("t2_rd", 32'(rd), 32'd7);
    chk("t2_we", 32'(we), 32'd1);
    chk("t2_data", data_in, 32'h1234);
    chk("t2_stall_wb", 32'(stall), 32'd1);
    cyc();
    chk("t2_stall_clear", 32'(stall), 32'd0);
    rs1 = 5'd0;

    // 3: two loads fill the queue, return in order (pointers wrap)
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd3; cyc();
    ld_issue_rd = 5'd4; cyc();
    ld_issue_rd = 5'd10;
    #1 chk("t3_full_ready", 32'(ld_issue_ready), 32'd0);
    chk("t3_pending", 32'(pending_cnt), 32'd2);
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA;
    cyc();
    chk("t3_rd_a", 32'(rd), 32'd3);
    chk("t3_data_a", data_in, 32'hA);
    mem_rdata = 32'hB;
    cyc();
    chk("t3_rd_b", 32'(rd), 32'd4);
    chk("t3_data_b", data_in, 32'hB);
    mem_rvalid = 1'b0;
    chk("t3_pending_empty", 32'(pending_cnt), 32'd0);

    // 4: load return beats ALU offer
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd6; cyc();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    #1 chk("t4_alu_blocked", 32'(alu_ready), 32'd0);
    cyc();
    chk("t4_rd_load", 32'(rd), 32'd6);
    chk("t4_data_load", data_in, 32'h66);
    mem_rvalid = 1'b0;
    #1 chk("t4_alu_ready", 32'(alu_ready), 32'd1);
    cyc();
    chk("t4_rd_alu", 32'(rd), 32'd9);
    chk("t4_data_alu", data_in, 32'h99);
    alu_valid = 1'b0;

    // 5: ALU and second load to a busy destination wait for the return
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd8; cyc();
    ld_issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hC0DE;
    #1 chk("t5_alu_busy", 32'(alu_ready), 32'd0);
    cyc();
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd8;
    #1 chk("t5_ld_busy", 32'(ld_issue_ready), 32'd0);
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h88;
    cyc();
    mem_rvalid = 1'b0;
    chk("t5_data_load", data_in, 32'h88);
    #1 chk("t5_alu_free", 32'(alu_ready), 32'd1);
    cyc();
    chk("t5_data_alu", data_in, 32'hC0DE);
    chk("t5_rd_alu", 32'(rd), 32'd8);

    // Same-cycle ALU write and load issue to x12; then an x0 load
    alu_rd = 5'd12; alu_data = 32'h1200;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
    cyc();
    alu_valid = 1'b0;
    ld_issue_rd = 5'd0;
    chk("t5b_data_alu", data_in, 32'h1200);
    chk("t5b_pending", 32'(pending_cnt), 32'd1);
    cyc();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1212;
    cyc();
    chk("t5b_data_load", data_in, 32'h1212);
    mem_rdata = 32'h0F0F;
    cyc();
    mem_rvalid = 1'b0;
    chk("t5b_x0_we", 32'(we), 32'd0);
    cyc();

    // 6: reset with two loads in flight, later return is spurious
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd3; cyc();
    ld_issue_rd = 5'd4; cyc();
    ld_issue_valid = 1'b0;
    rst = 1'b1;
    #1 chk("t6_rst_pending", 32'(pending_cnt), 32'd0);
    chk("t6_rst_we", 32'(we), 32'd0);
    chk("t6_rst_rd", 32'(rd), 32'd0);
    chk("t6_rst_data", data_in, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    cyc();
    mem_rvalid = 1'b0;
    chk("t6_err", 32'(err_spurious), 32'd1);
    chk("t6_no_write", 32'(we), 32'd0);
    cyc();
    chk("t6_err_sticky", 32'(err_spurious), 32'd1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
